// File: rtl/xvga_pkg.sv
// xvga_pkg: shared XVGA timing defaults, counter widths and timing descriptor helpers.
package xvga_pkg;

    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FP     = 24;
    localparam int unsigned DEF_H_SYNC   = 136;
    localparam int unsigned DEF_H_BP     = 160;

    localparam int unsigned DEF_V_ACTIVE = 768;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 29;

    // One axis of a video timing: visible region, front porch, sync pulse, back porch.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    function automatic int unsigned timing_total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int unsigned sync_first(timing_t t);
        return t.active + t.fp;
    endfunction

    function automatic int unsigned sync_last(timing_t t);
        return t.active + t.fp + t.sync - 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: enabled up-counter wrapping at MAX, exposing its next value and terminal flag.
module wrap_counter #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  MAX   = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             tc
);

    assign tc = (count == MAX);

    // Next value: hold when disabled, wrap to zero from MAX, otherwise increment.
    always_comb begin
        count_next = count;
        if (enable) begin
            count_next = tc ? '0 : count + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/xvga_timing_gen.sv
// xvga_timing_gen: XVGA raster timing generator (counters, syncs, blank, strobes).
// Optional feature: define XVGA_FRAME_COUNT_EN to build the completed-frame counter.
module xvga_timing_gen
    import xvga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           pixel_en,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           line_start,
    output logic           frame_start,
    output logic [7:0]     frame_count
);

    localparam timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    localparam logic [H_W-1:0] H_MAX    = H_W'(timing_total(H_TIM) - 1);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(sync_first(H_TIM));
    localparam logic [H_W-1:0] HS_LAST  = H_W'(sync_last(H_TIM));
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_ACTIVE);

    localparam logic [V_W-1:0] V_MAX    = V_W'(timing_total(V_TIM) - 1);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(sync_first(V_TIM));
    localparam logic [V_W-1:0] VS_LAST  = V_W'(sync_last(V_TIM));
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_ACTIVE);

    logic [H_W-1:0] h_next;
    logic [V_W-1:0] v_next;
    logic           h_tc;
    logic           v_tc;
    logic           line_wrap;
    logic           frame_wrap;
    logic           hsync_next;
    logic           vsync_next;
    logic           blank_next;

    assign line_wrap  = pixel_en & h_tc;
    assign frame_wrap = line_wrap & v_tc;

    wrap_counter #(
        .WIDTH (H_W),
        .MAX   (H_MAX)
    ) u_hcnt (
        .clock      (clock),
        .reset      (reset),
        .enable     (pixel_en),
        .count      (hcount),
        .count_next (h_next),
        .tc         (h_tc)
    );

    wrap_counter #(
        .WIDTH (V_W),
        .MAX   (V_MAX)
    ) u_vcnt (
        .clock      (clock),
        .reset      (reset),
        .enable     (line_wrap),
        .count      (vcount),
        .count_next (v_next),
        .tc         (v_tc)
    );

    // Decode syncs and blank from the counters' next values so they land on the same edge.
    always_comb begin
        hsync_next = ~((h_next >= HS_FIRST) && (h_next <= HS_LAST));
        vsync_next = ~((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        blank_next = (h_next >= H_VIS) || (v_next >= V_VIS);
    end

    // Output registers; strobes are held high through reset and fire only on a real wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            blank       <= blank_next;
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
        end
    end

`ifdef XVGA_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    // Completed-frame counter, bumped on each post-reset frame wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

endmodule
